// File: rtl/axilite_csr_write_addr.sv
// axilite_csr_write_addr
// AXI-Lite write-address front end for a CSR block. Accepts one AW beat,
// holds the latched address (with an aligned/in-range flag) for the
// downstream write-data stage, then issues the B response once that stage
// pulses deassert_addr. Counts SLVERR responses (saturating).
//
// Ports:
//   clk, rst          clock; asynchronous active-low reset
//   awaddr/awvalid/awready   AXI-Lite AW channel
//   addr, addr_good, addr_valid   latched address to write-data stage
//   deassert_addr     pulse from write-data stage: data beat consumed
//   bvalid/bresp/bready      AXI-Lite B channel
//   err_count         saturating count of SLVERR B handshakes
module axilite_csr_write_addr #(
  parameter logic [31:0] CSR_BASE  = 32'h0000_0000,
  parameter int unsigned CSR_COUNT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] awaddr,
  input  logic        awvalid,
  output logic        awready,
  output logic [31:0] addr,
  output logic        addr_good,
  output logic        addr_valid,
  input  logic        deassert_addr,
  output logic        bvalid,
  output logic [1:0]  bresp,
  input  logic        bready,
  output logic [7:0]  err_count
);

  typedef enum logic [1:0] {IDLE, HOLD, RESP} state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // 33-bit window bounds so BASE + 4*COUNT at the top of the map never wraps
  localparam logic [32:0] WIN_LO = {1'b0, CSR_BASE};
  localparam logic [32:0] WIN_HI = {1'b0, CSR_BASE} + 33'(CSR_COUNT) * 33'd4;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic        addr_good_q, addr_good_d;
  logic [1:0]  bresp_q, bresp_d;
  logic [7:0]  err_count_q, err_count_d;
  logic [32:0] awaddr_ext;
  logic        hit;

  assign awaddr_ext = {1'b0, awaddr};
  assign hit = (awaddr[1:0] == 2'b00) && (awaddr_ext >= WIN_LO) && (awaddr_ext < WIN_HI);

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    addr_good_d = addr_good_q;
    bresp_d     = bresp_q;
    err_count_d = err_count_q;
    unique case (state_q)
      IDLE: if (awvalid) begin
        addr_d      = awaddr;
        addr_good_d = hit;
        state_d     = HOLD;
      end
      // Bad addresses still wait for the data beat so W and B stay paired.
      HOLD: if (deassert_addr) begin
        bresp_d = addr_good_q ? RESP_OKAY : RESP_SLVERR;
        state_d = RESP;
      end
      RESP: if (bready) begin
        state_d = IDLE;
        if (bresp_q == RESP_SLVERR && err_count_q != 8'hFF)
          err_count_d = err_count_q + 8'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      addr_good_q <= 1'b0;
      bresp_q     <= RESP_OKAY;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      addr_good_q <= addr_good_d;
      bresp_q     <= bresp_d;
      err_count_q <= err_count_d;
    end
  end

  // Handshake outputs are pure state decodes; nothing combinational from inputs.
  assign awready    = (state_q == IDLE);
  assign addr_valid = (state_q == HOLD);
  assign bvalid     = (state_q == RESP);
  assign addr       = addr_q;
  assign addr_good  = addr_good_q;
  assign bresp      = bresp_q;
  assign err_count  = err_count_q;

endmodule
